// File: rtl/cache_fill_fsm.sv
// Miss-fill controller: stalls the pipeline, streams one word request per cycle
// for a 16-byte block, writes returned words into the data array, then the tag.
module cache_fill_fsm #(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              memory_data_valid,
  input  logic [DATA_W-1:0] memory_data,
  output logic              fsm_busy,
  output logic              memory_request,
  output logic [ADDR_W-1:0] memory_address,
  output logic              write_data_array,
  output logic [2:0]        fill_word,
  output logic [DATA_W-1:0] fill_data,
  output logic              write_tag_array
);

  localparam int OFF_W  = $clog2(BLOCK_WORDS);
  localparam int CNT_W  = OFF_W + 1;
  localparam int BASE_W = ADDR_W - OFF_W - 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_FILL = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [BASE_W-1:0]  r_base;
  logic [CNT_W-1:0]   r_req_cnt;
  logic [OFF_W-1:0]   r_rsp_cnt;

  logic               w_in_fill;
  logic               w_req_open;
  logic               w_last_rsp;
  logic               w_start;

  assign w_in_fill  = (r_state == S_FILL);
  assign w_req_open = (r_req_cnt < CNT_W'(BLOCK_WORDS));
  assign w_last_rsp = w_in_fill && memory_data_valid &&
                      (r_rsp_cnt == OFF_W'(BLOCK_WORDS - 1));
  assign w_start    = (r_state == S_IDLE) && miss_detected;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; a miss during FILL never restarts the fill
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (miss_detected) w_state_nxt = S_FILL;
      S_FILL: if (w_last_rsp)    w_state_nxt = S_IDLE;
      default:                   w_state_nxt = S_IDLE;
    endcase
  end

  // Block base and request/response word counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_base    <= '0;
      r_req_cnt <= '0;
      r_rsp_cnt <= '0;
    end else if (w_start) begin
      r_base    <= miss_address[ADDR_W-1:OFF_W+1];
      r_req_cnt <= '0;
      r_rsp_cnt <= '0;
    end else if (w_in_fill) begin
      if (w_req_open) begin
        r_req_cnt <= r_req_cnt + CNT_W'(1);
      end
      if (memory_data_valid) begin
        r_rsp_cnt <= r_rsp_cnt + OFF_W'(1);
      end
    end
  end

  assign fill_data = memory_data;

  // Output decode; busy rises combinationally in the detection cycle
  always_comb begin
    fsm_busy         = 1'b0;
    memory_request   = 1'b0;
    memory_address   = '0;
    write_data_array = 1'b0;
    fill_word        = '0;
    write_tag_array  = 1'b0;
    case (r_state)
      S_IDLE: begin
        fsm_busy = miss_detected;
      end
      S_FILL: begin
        fsm_busy       = 1'b1;
        memory_request = w_req_open;
        memory_address = {r_base, r_req_cnt[OFF_W-1:0], 1'b0};
        if (memory_data_valid) begin
          write_data_array = 1'b1;
          fill_word        = r_rsp_cnt;
        end
        write_tag_array = w_last_rsp;
      end
      default: begin
        fsm_busy = 1'b0;
      end
    endcase
  end

endmodule
